// File: rtl/noc_pkg.sv
// noc_pkg: shared definitions for the mesh router.
//   - port index enum (PE, LEFT, RIGHT, UP, DOWN) and NPORTS
//   - packet field offset helpers, parametrised by ADDR_W / DATA_W
//   - dimension-ordered route function and a modulo-NPORTS increment
// Packet layout, MSB->LSB: flag | dest_x | dest_y | src_x | src_y | payload
package noc_pkg;

    localparam int NPORTS = 5;

    typedef enum logic [2:0] {
        PE    = 3'd0,
        LEFT  = 3'd1,
        RIGHT = 3'd2,
        UP    = 3'd3,
        DOWN  = 3'd4
    } port_e;

    function automatic int pkt_width(input int addr_w, input int data_w);
        return 1 + 4 * addr_w + data_w;
    endfunction

    function automatic int dest_x_lsb(input int addr_w, input int data_w);
        return data_w + 3 * addr_w;
    endfunction

    function automatic int dest_y_lsb(input int addr_w, input int data_w);
        return data_w + 2 * addr_w;
    endfunction

    function automatic int src_x_lsb(input int addr_w, input int data_w);
        return data_w + addr_w;
    endfunction

    function automatic int src_y_lsb(input int addr_w, input int data_w);
        return data_w;
    endfunction

    // Dimension-ordered routing; the preferred dimension is resolved first
    // and the other one is only consulted once the first coordinate matches.
    function automatic port_e route(input int unsigned dest_x, input int unsigned dest_y,
                                    input int unsigned my_x, input int unsigned my_y,
                                    input logic yx);
        port_e x_port;
        port_e y_port;
        if (dest_x > my_x)      x_port = RIGHT;
        else if (dest_x < my_x) x_port = LEFT;
        else                    x_port = PE;
        if (dest_y > my_y)      y_port = UP;
        else if (dest_y < my_y) y_port = DOWN;
        else                    y_port = PE;
        if (yx) return (y_port != PE) ? y_port : x_port;
        return (x_port != PE) ? x_port : y_port;
    endfunction

    // (base + offset) mod NPORTS for base, offset < NPORTS.
    function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] offset);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        return (sum >= 4'(NPORTS)) ? 3'(sum - 4'(NPORTS)) : sum[2:0];
    endfunction

endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: synchronous input buffer with a registered occupancy count.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   push, wr_data     write strobe and data (caller guarantees !full)
//   pop, rd_data      read strobe (caller guarantees !empty); rd_data is the head
//   full, empty       decoded from the registered count only
module noc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; validity is tracked by count,
    // so clearing the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_router_sync.sv
// noc_router_sync: 5-port buffered mesh router (PE, LEFT, RIGHT, UP, DOWN).
// Ports (all arrays indexed by port: PE=0, LEFT=1, RIGHT=2, UP=3, DOWN=4):
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   in_data/in_valid/in_ready  per-input valid/ready push into that port's FIFO
//   out_data/out_valid/out_ready  per-output single-entry register, valid/ready
//   out_count                 delivered packets per output, wraps at 16 bits
module noc_router_sync
    import noc_pkg::*;
#(
    parameter int MY_X       = 1,
    parameter int MY_Y       = 1,
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 4,
    parameter int ROUTE_YX   = 0,
    localparam int PKT_W     = 1 + 4 * ADDR_W + DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PKT_W-1:0]   in_data   [NPORTS],
    input  logic [NPORTS-1:0]  in_valid,
    output logic [NPORTS-1:0]  in_ready,
    output logic [PKT_W-1:0]   out_data  [NPORTS],
    output logic [NPORTS-1:0]  out_valid,
    input  logic [NPORTS-1:0]  out_ready,
    output logic [15:0]        out_count [NPORTS]
);

    localparam int DX_LSB = dest_x_lsb(ADDR_W, DATA_W);
    localparam int DY_LSB = dest_y_lsb(ADDR_W, DATA_W);

    // Holds in_ready low until the first edge after reset release.
    logic              started;
    logic [NPORTS-1:0] fifo_full;
    logic [NPORTS-1:0] fifo_empty;
    logic [NPORTS-1:0] push;
    logic [NPORTS-1:0] pop;
    logic [PKT_W-1:0]  head      [NPORTS];
    port_e             head_port [NPORTS];
    logic [NPORTS-1:0] gnt_valid;
    logic [2:0]        gnt_idx   [NPORTS];
    logic [2:0]        rr_ptr    [NPORTS];

    assign in_ready = started ? ~fifo_full : '0;
    assign push     = in_valid & in_ready;

    for (genvar i = 0; i < NPORTS; i++) begin : g_in
        noc_fifo #(
            .WIDTH (PKT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push    (push[i]),
            .wr_data (in_data[i]),
            .pop     (pop[i]),
            .rd_data (head[i]),
            .full    (fifo_full[i]),
            .empty   (fifo_empty[i])
        );

        assign head_port[i] = route(32'(head[i][DX_LSB +: ADDR_W]),
                                    32'(head[i][DY_LSB +: ADDR_W]),
                                    MY_X, MY_Y, ROUTE_YX != 0);
    end

    // Per-output round-robin: first requester at or after rr_ptr, cyclically.
    // An output competes only when its register is empty or draining now.
    // NOTE: every combinational output gets a default before any condition,
    // otherwise untaken paths would infer latches.
    always_comb begin
        pop       = '0;
        gnt_valid = '0;
        for (int o = 0; o < NPORTS; o++) begin
            gnt_idx[o] = '0;
            if (!out_valid[o] || out_ready[o]) begin
                for (int k = 0; k < NPORTS; k++) begin
                    if (!gnt_valid[o]
                        && !fifo_empty[wrap_add(rr_ptr[o], 3'(k))]
                        && head_port[wrap_add(rr_ptr[o], 3'(k))] == port_e'(o)) begin
                        gnt_valid[o] = 1'b1;
                        gnt_idx[o]   = wrap_add(rr_ptr[o], 3'(k));
                    end
                end
            end
            // A head has a single destination, so at most one output pops it.
            if (gnt_valid[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started   <= 1'b0;
            out_valid <= '0;
            for (int o = 0; o < NPORTS; o++) begin
                out_data[o]  <= '0;
                out_count[o] <= '0;
                rr_ptr[o]    <= '0;
            end
        end else begin
            started <= 1'b1;
            for (int o = 0; o < NPORTS; o++) begin
                // A grant overrides a drain, giving back-to-back transfers.
                if (gnt_valid[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o]  <= head[gnt_idx[o]];
                    rr_ptr[o]    <= wrap_add(gnt_idx[o], 3'd1);
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
                if (out_valid[o] && out_ready[o]) out_count[o] <= out_count[o] + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_noc_router_sync.sv
// Self-checking bench for noc_router_sync at MY=(1,1), default widths.
// Directed scenarios for timing/arbitration/backpressure/reset, then random
// traffic checked against a per (input,output) queue scoreboard.
module tb_noc_router_sync;

    localparam int NP     = 5;
    localparam int PKT_W  = 33;
    localparam int P_PE = 0, P_LEFT = 1, P_RIGHT = 2, P_UP = 3, P_DOWN = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [PKT_W-1:0] in_data   [NP];
    logic [NP-1:0]    in_valid, in_ready, out_valid, out_ready;
    logic [PKT_W-1:0] out_data  [NP];
    logic [15:0]      out_count [NP];

    logic [PKT_W-1:0] y_in_data   [NP];
    logic [NP-1:0]    y_in_valid, y_in_ready, y_out_valid, y_out_ready;
    logic [PKT_W-1:0] y_out_data  [NP];
    logic [15:0]      y_out_count [NP];

    noc_router_sync #(
        .MY_X(1), .MY_Y(1), .ADDR_W(2), .DATA_W(24), .FIFO_DEPTH(4), .ROUTE_YX(0)
    ) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count)
    );

    noc_router_sync #(
        .MY_X(1), .MY_Y(1), .ADDR_W(2), .DATA_W(24), .FIFO_DEPTH(4), .ROUTE_YX(1)
    ) dut_yx (
        .clk(clk), .reset(reset),
        .in_data(y_in_data), .in_valid(y_in_valid), .in_ready(y_in_ready),
        .out_data(y_out_data), .out_valid(y_out_valid), .out_ready(y_out_ready),
        .out_count(y_out_count)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PKT_W-1:0] mk_pkt(input int flag, input int dx, input int dy,
                                                 input int sx, input int sy, input int payload);
        return {1'(flag), 2'(dx), 2'(dy), 2'(sx), 2'(sy), 24'(payload)};
    endfunction

    // Reference routing at MY=(1,1): dest_x in [31:30], dest_y in [29:28].
    function automatic int ref_port(input logic [PKT_W-1:0] p, input bit yx);
        int dx, dy, h, v;
        dx = int'(p[31:30]);
        dy = int'(p[29:28]);
        h  = (dx > 1) ? P_RIGHT : (dx < 1) ? P_LEFT : P_PE;
        v  = (dy > 1) ? P_UP    : (dy < 1) ? P_DOWN : P_PE;
        if (yx) return (v != P_PE) ? v : h;
        return (h != P_PE) ? h : v;
    endfunction

    // Scoreboard: expected packets per (input, output) in arrival order.
    logic [PKT_W-1:0] exp_q [NP][NP][$];
    int               exp_cnt   [NP];
    bit               held      [NP];
    logic [PKT_W-1:0] held_data [NP];
    bit               hit;

    always @(negedge clk) begin
        if (reset) begin
            for (int o = 0; o < NP; o++) held[o] = 1'b0;
        end else begin
            for (int i = 0; i < NP; i++)
                if (in_valid[i] && in_ready[i])
                    exp_q[i][ref_port(in_data[i], 1'b0)].push_back(in_data[i]);
            for (int o = 0; o < NP; o++) begin
                if (held[o]) begin
                    check("hold_valid", 64'(out_valid[o]), 64'd1);
                    check("hold_data", 64'(out_data[o]), 64'(held_data[o]));
                end
                held[o]      = out_valid[o] && !out_ready[o];
                held_data[o] = out_data[o];
                if (out_valid[o] && out_ready[o]) begin
                    hit = 1'b0;
                    for (int i = 0; i < NP; i++) begin
                        if (!hit && exp_q[i][o].size() > 0 && exp_q[i][o][0] === out_data[o]) begin
                            hit = 1'b1;
                            void'(exp_q[i][o].pop_front());
                        end
                    end
                    check($sformatf("deliver_port%0d", o), 64'(hit), 64'd1);
                    exp_cnt[o] = (exp_cnt[o] + 1) & 16'hFFFF;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = '0;
        y_in_valid = '0;
        for (int i = 0; i < NP; i++) begin
            in_data[i]   = '0;
            y_in_data[i] = '0;
        end
    endtask

    task automatic flush_model();
        for (int i = 0; i < NP; i++)
            for (int o = 0; o < NP; o++) exp_q[i][o].delete();
        for (int o = 0; o < NP; o++) exp_cnt[o] = 0;
    endtask

    logic [PKT_W-1:0] p, pa, pb, p0, p1;
    logic [PKT_W-1:0] bp_pkts [6];
    int               k, seq;
    bit               will;

    initial begin
        idle_inputs();
        out_ready   = '1;
        y_out_ready = '1;
        flush_model();
        for (int o = 0; o < NP; o++) held[o] = 1'b0;

        // Reset state, before any clock edge.
        #2;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        for (int o = 0; o < NP; o++) begin
            check("rst_out_data", 64'(out_data[o]), 64'd0);
            check("rst_out_count", 64'(out_count[o]), 64'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("pre_edge_in_ready", 64'(in_ready), 64'd0);
        step();
        check("start_in_ready", 64'(in_ready), 64'h1F);

        // XY forward: LEFT -> RIGHT, 2-cycle latency.
        p = mk_pkt(0, 2, 1, 0, 1, 'h000155);
        in_data[P_LEFT] = p; in_valid[P_LEFT] = 1'b1;
        step();
        in_valid = '0;
        check("fwd_early_valid", 64'(out_valid[P_RIGHT]), 64'd0);
        step();
        check("fwd_valid", 64'(out_valid[P_RIGHT]), 64'd1);
        check("fwd_data", 64'(out_data[P_RIGHT]), 64'(p));
        step();
        check("fwd_count", 64'(out_count[P_RIGHT]), 64'd1);
        check("fwd_drained", 64'(out_valid[P_RIGHT]), 64'd0);

        // Local delivery, both flag values preserved.
        p0 = mk_pkt(0, 1, 1, 1, 2, 'h0A0A0A);
        p1 = mk_pkt(1, 1, 1, 1, 2, 'h0B0B0B);
        in_data[P_UP] = p0; in_valid[P_UP] = 1'b1;
        step();
        in_data[P_UP] = p1;
        step();
        in_valid = '0;
        check("local_valid0", 64'(out_valid[P_PE]), 64'd1);
        check("local_flag0", 64'(out_data[P_PE]), 64'(p0));
        step();
        check("local_valid1", 64'(out_valid[P_PE]), 64'd1);
        check("local_flag1", 64'(out_data[P_PE]), 64'(p1));
        step();

        // Contention on UP: LEFT then DOWN, twice (pointer wraps to 0).
        pa = mk_pkt(0, 1, 3, 0, 1, 'h0000AA);
        pb = mk_pkt(0, 1, 3, 1, 0, 'h0000BB);
        for (int rep = 0; rep < 2; rep++) begin
            in_data[P_LEFT] = pa; in_data[P_DOWN] = pb;
            in_valid[P_LEFT] = 1'b1; in_valid[P_DOWN] = 1'b1;
            step();
            in_valid = '0;
            step();
            check("cont_first_valid", 64'(out_valid[P_UP]), 64'd1);
            check("cont_first", 64'(out_data[P_UP]), 64'(pa));
            step();
            check("cont_second_valid", 64'(out_valid[P_UP]), 64'd1);
            check("cont_second", 64'(out_data[P_UP]), 64'(pb));
            step();
        end

        // Backpressure on RIGHT: FIFO_DEPTH + 1 packets absorbed.
        out_ready[P_RIGHT] = 1'b0;
        for (int j = 0; j < 6; j++) bp_pkts[j] = mk_pkt(0, 3, 1, 1, 1, 'h400 + j);
        k = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (k < 6) begin
                in_data[P_PE]  = bp_pkts[k];
                in_valid[P_PE] = 1'b1;
            end else begin
                in_valid[P_PE] = 1'b0;
            end
            will = in_valid[P_PE] && in_ready[P_PE];
            step();
            if (will) k++;
        end
        in_valid = '0;
        check("bp_accepted", 64'(k), 64'd5);
        check("bp_in_ready", 64'(in_ready[P_PE]), 64'd0);
        check("bp_head_valid", 64'(out_valid[P_RIGHT]), 64'd1);
        check("bp_head", 64'(out_data[P_RIGHT]), 64'(bp_pkts[0]));
        out_ready[P_RIGHT] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            check("bp_drain_valid", 64'(out_valid[P_RIGHT]), 64'd1);
            check("bp_drain_data", 64'(out_data[P_RIGHT]), 64'(bp_pkts[j]));
            step();
        end
        check("bp_done", 64'(out_valid[P_RIGHT]), 64'd0);

        // YX vs XY on the same packet.
        p = mk_pkt(0, 2, 3, 1, 1, 'h0000C3);
        in_data[P_PE] = p; in_valid[P_PE] = 1'b1;
        y_in_data[P_PE] = p; y_in_valid[P_PE] = 1'b1;
        step();
        in_valid = '0; y_in_valid = '0;
        step();
        check("yx_up_valid", 64'(y_out_valid[P_UP]), 64'd1);
        check("yx_up_data", 64'(y_out_data[P_UP]), 64'(p));
        check("yx_not_right", 64'(y_out_valid[P_RIGHT]), 64'd0);
        check("xy_right_valid", 64'(out_valid[P_RIGHT]), 64'd1);
        check("xy_right_data", 64'(out_data[P_RIGHT]), 64'(p));
        step();
        check("yx_count", 64'(y_out_count[P_UP]), 64'd1);

        // Reset mid-stream with 3 packets buffered.
        out_ready[P_RIGHT] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_data[P_PE] = mk_pkt(0, 3, 1, 1, 1, 'h900 + j); in_valid[P_PE] = 1'b1;
            step();
        end
        in_valid = '0;
        step();
        check("mid_valid_before", 64'(out_valid[P_RIGHT]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_async_valid", 64'(out_valid), 64'd0);
        check("mid_async_ready", 64'(in_ready), 64'd0);
        flush_model();
        step();
        step();
        reset = 1'b0;
        out_ready = '1;
        for (int c = 0; c < 8; c++) begin
            step();
            check("post_rst_idle", 64'(out_valid), 64'd0);
        end
        for (int o = 0; o < NP; o++) check("post_rst_count", 64'(out_count[o]), 64'd0);

        // Random traffic against the scoreboard.
        seq = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NP; i++) begin
                in_valid[i] = ($urandom_range(0, 99) < 60);
                in_data[i]  = mk_pkt(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                                     int'($urandom_range(0, 3)), i, 0,
                                     (i << 20) | (seq & 'hFFFFF));
                seq++;
            end
            for (int o = 0; o < NP; o++) out_ready[o] = ($urandom_range(0, 99) < 70);
            step();
        end
        in_valid  = '0;
        out_ready = '1;
        for (int c = 0; c < 40; c++) step();
        check("final_idle", 64'(out_valid), 64'd0);
        for (int i = 0; i < NP; i++)
            for (int o = 0; o < NP; o++)
                check($sformatf("leftover_%0d_%0d", i, o), 64'(exp_q[i][o].size()), 64'd0);
        for (int o = 0; o < NP; o++)
            check($sformatf("count_port%0d", o), 64'(out_count[o]), 64'(exp_cnt[o]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_router_sync.md
# noc_router_sync

Clocked, parametrised 5-port mesh router for the NoC: PE, LEFT, RIGHT, UP, DOWN. Each input port has a FIFO. Each head packet is steered by dimension-ordered routing, XY or YX (set at elaboration). Each output port has a round-robin arbiter and a single-entry output register. It replaces the unbuffered, fixed-function router as the tile-level switch, with configurable coordinates, field widths, buffer depth and routing mode.

## Interface
- MY_X, 1: X coordinate of this router
- MY_Y, 1: Y coordinate of this router
- ADDR_W, 2: bits per coordinate field
- DATA_W, 24: payload bits
- FIFO_DEPTH, 4: entries per input FIFO; power of 2, ≥2
- ROUTE_YX, 0: 0 = XY order, 1 = YX order
- PKT_W, derived = 1 + 4*ADDR_W + DATA_W (33 at defaults)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- in_data[5]  in  PKT_W  packet per input port; index PE=0, LEFT=1, RIGHT=2, UP=3, DOWN=4
- in_valid[5]  in  1  input packet valid
- in_ready[5]  out  1  input FIFO can accept
- out_data[5]  out  PKT_W  packet per output port, same indexing
- out_valid[5]  out  1  output register full
- out_ready[5]  in  1  downstream accepts
- out_count[5]  out  16  packets delivered per output port; wraps

## Operation
- Packet layout, MSB→LSB:
  - flag [PKT_W-1], passed through untouched
  - dest_x, dest_y
  - src_x, src_y
  - payload [DATA_W-1:0]
- Routing, XY mode:
  - dest_x > MY_X → RIGHT; dest_x < MY_X → LEFT
  - otherwise dest_y > MY_Y → UP; dest_y < MY_Y → DOWN
  - otherwise PE
- Routing, YX mode: compare Y first, then X. Comparisons are unsigned.
- U-turn (output equals arrival port) is legal and forwarded unchanged.
- Input side:
  - push on in_valid && in_ready.
  - in_ready = FIFO not full, from the registered occupancy count. A pop in the same cycle does not raise it.
- Per-output arbitration:
  - requesters are the non-empty inputs whose head routes to this output.
  - an output is eligible when its register is empty or draining this cycle (out_valid && out_ready).
  - grant goes to the first requester at or after rr_ptr, searching cyclically 0..4.
  - on grant, the head is popped and written to the output register, and rr_ptr = granted index + 1 mod 5.
  - rr_ptr is unchanged when there is no grant.
- Each head has exactly one destination, so no input is granted twice in one cycle.
- Output side:
  - out_valid stays high and out_data stays stable until out_ready is sampled high.
  - a drain and a reload of the same register in one cycle is allowed and gives back-to-back transfers.
- out_count[p] increments on every out_valid && out_ready, wrapping 0xFFFF→0.
- Packets are never dropped, duplicated or modified.
- Order is preserved per input→output pair.

## Timing
- Reset asserted (asynchronous):
  - all FIFOs empty; in_ready = 0
  - out_valid = 0, out_data = 0, out_count = 0, rr_ptr = 0
- First edge after deassertion: in_ready = 1.
- Reset mid-operation flushes all buffered packets immediately. Handshakes in progress are abandoned.
- Latency, uncontended:
  - push at edge N; head visible in cycle N+1
  - arbitration and output-register load at edge N+1
  - out_valid high in cycle N+2, i.e. 2 cycles
- Throughput: one packet per output per cycle.
- Full buffering per input→output: FIFO_DEPTH + 1 packets when that output is stalled, the extra one being in the output register.

## Structure
- Package noc_pkg:
  - port index constants (PE, LEFT, RIGHT, UP, DOWN) and NPORTS = 5
  - packet field offset functions parametrised by ADDR_W and DATA_W
  - route function (dest, my, yx) → port index
- Sub-module noc_fifo, one per input port:
  - parameters WIDTH and DEPTH
  - registered count; push/pop; full/empty
  - async active-high reset
- Arbiters, output registers and counters stay in the top module.

## Test plan
All scenarios use MY=(1,1), defaults unless stated; packets are written as dest (x,y), payload.
- XY forward: LEFT in, dest (2,1), payload 0x000155 → RIGHT out_valid exactly 2 cycles later; data bit-identical; out_count[RIGHT] = 1.
- Local delivery: UP in, dest (1,1) → PE out; flag bit 0 and bit 1 both preserved.
- Contention: LEFT and DOWN push dest (1,3) in the same cycle → UP delivers LEFT's packet then DOWN's on consecutive cycles. Repeat both again: LEFT first again (rr_ptr wrapped past 4 to 0).
- Backpressure: RIGHT out_ready = 0; PE pushes 6 packets to (3,1) →
  - exactly 5 accepted (4 in FIFO + 1 in output register); in_ready[PE] = 0
  - releasing out_ready drains them in order, one per cycle
- YX mode (ROUTE_YX = 1): PE in, dest (2,3) → UP, not RIGHT. With XY, the same packet → RIGHT.
- Reset mid-stream: reset asserted with 3 packets buffered →
  - out_valid drops in the same cycle with no clock edge
  - after release, counters are 0 and nothing is emitted
